// File: rtl/arc4_decrypt.sv
// ARC4 decrypt engine: 24-bit key, length-prefixed ct RAM in, length-prefixed pt RAM out.
// Latency: 1 + 256 (init) + 5*256 (key schedule) + 4 + 8*L cycles from en to rdy.
// Backpressure: none; en is taken only while rdy=1, and RAM ports are assumed always ready.
module arc4_decrypt (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [7:0]  ct_addr,
   input  logic [7:0]  ct_rddata,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata,
   output logic [7:0]  pt_wrdata,
   output logic        pt_wren
);

   typedef enum logic [4:0] {
      S_IDLE,
      S_INIT,
      K_RD_I,
      K_CALC_J,
      K_RD_J,
      K_WR_I,
      K_WR_J,
      P_LEN_WAIT,
      P_LEN,
      P_CHECK,
      P_RD_I,
      P_CALC_J,
      P_RD_J,
      P_WR_I,
      P_WR_J,
      P_RD_PAD,
      P_XOR,
      P_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  i_q, i_d;
   logic [7:0]  j_q, j_d;
   logic [8:0]  k_q, k_d;
   logic [1:0]  km_q, km_d;
   logic [7:0]  si_q, si_d;
   logic [7:0]  sj_q, sj_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  ct_addr_q, ct_addr_d;
   logic [7:0]  pt_addr_q, pt_addr_d;
   logic [7:0]  pt_wrdata_q, pt_wrdata_d;
   logic        pt_wren_q, pt_wren_d;

   logic [7:0]  s_mem [256];
   logic [7:0]  s_addr;
   logic [7:0]  s_wdata;
   logic [7:0]  s_q;
   logic        s_wren;
   logic [7:0]  key_byte;
   logic        unused_pt_rd;

   assign unused_pt_rd = ^pt_rddata;

   assign ct_addr   = ct_addr_q;
   assign pt_addr   = pt_addr_q;
   assign pt_wrdata = pt_wrdata_q;
   assign pt_wren   = pt_wren_q;

   // S RAM: single port, registered read, write on the enabled edge
   always_ff @(posedge clk) begin
      if (s_wren) begin
         s_mem[s_addr] <= s_wdata;
      end
      s_q <= s_mem[s_addr];
   end

   always_comb begin
      key_byte = key[23:16];
      case (km_q)
         2'd1:    key_byte = key[15:8];
         2'd2:    key_byte = key[7:0];
         default: key_byte = key[23:16];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         i_q         <= 8'd0;
         j_q         <= 8'd0;
         k_q         <= 9'd0;
         km_q        <= 2'd0;
         si_q        <= 8'd0;
         sj_q        <= 8'd0;
         len_q       <= 8'd0;
         ct_addr_q   <= 8'd0;
         pt_addr_q   <= 8'd0;
         pt_wrdata_q <= 8'd0;
         pt_wren_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         k_q         <= k_d;
         km_q        <= km_d;
         si_q        <= si_d;
         sj_q        <= sj_d;
         len_q       <= len_d;
         ct_addr_q   <= ct_addr_d;
         pt_addr_q   <= pt_addr_d;
         pt_wrdata_q <= pt_wrdata_d;
         pt_wren_q   <= pt_wren_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      k_d         = k_q;
      km_d        = km_q;
      si_d        = si_q;
      sj_d        = sj_q;
      len_d       = len_q;
      ct_addr_d   = ct_addr_q;
      pt_addr_d   = pt_addr_q;
      pt_wrdata_d = pt_wrdata_q;
      pt_wren_d   = 1'b0;
      s_addr      = i_q;
      s_wdata     = 8'd0;
      s_wren      = 1'b0;
      rdy         = 1'b0;

      case (state_q)
         S_IDLE: begin
            rdy = 1'b1;
            if (en) begin
               state_d = S_INIT;
               i_d     = 8'd0;
               j_d     = 8'd0;
               km_d    = 2'd0;
            end
         end
         S_INIT: begin
            s_wren  = 1'b1;
            s_addr  = i_q;
            s_wdata = i_q;
            i_d     = i_q + 8'd1;
            if (i_q == 8'hFF) begin
               state_d = K_RD_I;
            end
         end
         K_RD_I: begin
            s_addr  = i_q;
            state_d = K_CALC_J;
         end
         K_CALC_J: begin
            si_d    = s_q;
            j_d     = j_q + s_q + key_byte;
            state_d = K_RD_J;
         end
         K_RD_J: begin
            s_addr  = j_q;
            state_d = K_WR_I;
         end
         K_WR_I: begin
            s_wren  = 1'b1;
            s_addr  = i_q;
            s_wdata = s_q;
            state_d = K_WR_J;
         end
         K_WR_J: begin
            s_wren  = 1'b1;
            s_addr  = j_q;
            s_wdata = si_q;
            i_d     = i_q + 8'd1;
            km_d    = (km_q == 2'd2) ? 2'd0 : km_q + 2'd1;
            if (i_q == 8'hFF) begin
               // i wraps to 0 here, which is also the PRGA starting index
               state_d   = P_LEN_WAIT;
               j_d       = 8'd0;
               k_d       = 9'd1;
               ct_addr_d = 8'd0;
            end else begin
               state_d = K_RD_I;
            end
         end
         P_LEN_WAIT: begin
            state_d = P_LEN;
         end
         P_LEN: begin
            len_d       = ct_rddata;
            pt_addr_d   = 8'd0;
            pt_wrdata_d = ct_rddata;
            pt_wren_d   = 1'b1;
            state_d     = P_CHECK;
         end
         P_CHECK: begin
            // 9-bit k lets L=255 finish once k reaches 256
            if (k_q > {1'b0, len_q}) begin
               state_d = P_DONE;
            end else begin
               i_d       = i_q + 8'd1;
               ct_addr_d = k_q[7:0];
               state_d   = P_RD_I;
            end
         end
         P_RD_I: begin
            s_addr  = i_q;
            state_d = P_CALC_J;
         end
         P_CALC_J: begin
            si_d    = s_q;
            j_d     = j_q + s_q;
            state_d = P_RD_J;
         end
         P_RD_J: begin
            s_addr  = j_q;
            state_d = P_WR_I;
         end
         P_WR_I: begin
            sj_d    = s_q;
            s_wren  = 1'b1;
            s_addr  = i_q;
            s_wdata = s_q;
            state_d = P_WR_J;
         end
         P_WR_J: begin
            s_wren  = 1'b1;
            s_addr  = j_q;
            s_wdata = si_q;
            state_d = P_RD_PAD;
         end
         P_RD_PAD: begin
            s_addr  = si_q + sj_q;
            state_d = P_XOR;
         end
         P_XOR: begin
            pt_wrdata_d = s_q ^ ct_rddata;
            pt_addr_d   = k_q[7:0];
            pt_wren_d   = 1'b1;
            k_d         = k_q + 9'd1;
            state_d     = P_CHECK;
         end
         P_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_arc4_decrypt.sv
// Bench for arc4_decrypt: RAM models, fixed vectors, handshake/reset sequences, random runs vs RC4 model.
module tb_arc4_decrypt;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  ct_addr;
   logic [7:0]  ct_rddata;
   logic [7:0]  pt_addr;
   logic [7:0]  pt_rddata;
   logic [7:0]  pt_wrdata;
   logic        pt_wren;

   always #5 clk = ~clk;

   arc4_decrypt dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .rdy       (rdy),
      .key       (key),
      .ct_addr   (ct_addr),
      .ct_rddata (ct_rddata),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .pt_wrdata (pt_wrdata),
      .pt_wren   (pt_wren)
   );

   logic [7:0] ct_mem [256];
   logic [7:0] pt_mem [256];
   logic [7:0] exp_pt [256];
   logic       tb_clr;
   int         wr_cnt;
   int         order_err;
   int         wr_while_rdy;
   int         tests = 0;
   int         fails = 0;

   // external RAMs: registered address, one-cycle read latency
   always @(posedge clk) begin
      ct_rddata <= ct_mem[ct_addr];
      pt_rddata <= pt_mem[pt_addr];
      if (tb_clr) begin
         for (int a = 0; a < 256; a++) pt_mem[a] <= ~exp_pt[a];
      end else if (pt_wren) begin
         pt_mem[pt_addr] <= pt_wrdata;
      end
   end

   always @(negedge clk) begin
      if (tb_clr) begin
         wr_cnt       <= 0;
         order_err    <= 0;
         wr_while_rdy <= 0;
      end else if (pt_wren) begin
         if (int'(pt_addr) != wr_cnt) order_err <= order_err + 1;
         if (rdy) wr_while_rdy <= wr_while_rdy + 1;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic clear();
      tb_clr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tb_clr = 1'b0;
      @(negedge clk);
   endtask

   // plain RC4 over the bench's ct_mem, result in exp_pt
   task automatic model(input logic [23:0] k);
      int s [256];
      int i, j, t, len;
      for (int n = 0; n < 256; n++) s[n] = n;
      j = 0;
      for (i = 0; i < 256; i++) begin
         j = (j + s[i] + int'(k[8*(2-(i%3)) +: 8])) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
      end
      for (int n = 0; n < 256; n++) exp_pt[n] = 8'd0;
      len = int'(ct_mem[0]);
      exp_pt[0] = ct_mem[0];
      i = 0;
      j = 0;
      for (int n = 1; n <= len; n++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         exp_pt[n] = ct_mem[n] ^ 8'(s[(s[i] + s[j]) % 256]);
      end
   endtask

   task automatic wait_done(input string nm, input int len);
      int cyc = 0;
      while (rdy !== 1'b1 && cyc < 2000 + 8*len + 16) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_done"}, rdy, 1);
      @(negedge clk);
   endtask

   task automatic check_result(input string nm);
      int len = int'(ct_mem[0]);
      chk({nm, "_wr_count"}, wr_cnt, len + 1);
      chk({nm, "_wr_order"}, order_err, 0);
      chk({nm, "_wr_while_rdy"}, wr_while_rdy, 0);
      for (int b = 0; b <= len; b++)
         chk($sformatf("%s_pt[%0d]", nm, b), pt_mem[b], exp_pt[b]);
   endtask

   task automatic run(input logic [23:0] k, input string nm);
      clear();
      key = k;
      en  = 1'b1;
      @(negedge clk);
      en  = 1'b0;
      chk({nm, "_rdy_fall"}, rdy, 0);
      wait_done(nm, int'(ct_mem[0]));
      check_result(nm);
   endtask

   typedef struct {
      logic [23:0] key;
      logic [7:0]  len;
      logic [71:0] ct;
      logic [71:0] pt;
   } vec_t;

   vec_t vecs [3];

   task automatic load_vec(input int v);
      for (int a = 0; a < 256; a++) begin
         ct_mem[a] = 8'($urandom);
         exp_pt[a] = 8'd0;
      end
      ct_mem[0] = vecs[v].len;
      exp_pt[0] = vecs[v].len;
      for (int b = 1; b <= 9; b++) begin
         ct_mem[b] = vecs[v].ct[8*(9-b) +: 8];
         exp_pt[b] = vecs[v].pt[8*(9-b) +: 8];
      end
   endtask

   initial begin
      int bad;
      vecs[0] = '{24'h4B6579, 8'd9, 72'hBBF316E8D940AF0AD3, 72'h506C61696E74657874};
      vecs[1] = '{24'h4B6579, 8'd3, 72'h000000000000000000, 72'hEB9F77000000000000};
      vecs[2] = '{24'h4B6579, 8'd0, 72'h000000000000000000, 72'h000000000000000000};

      for (int a = 0; a < 256; a++) begin
         ct_mem[a] = 8'd0;
         exp_pt[a] = 8'd0;
      end
      rst    = 1'b1;
      en     = 1'b0;
      key    = 24'd0;
      tb_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_rdy", rdy, 1);
      chk("reset_pt_wren", pt_wren, 0);
      chk("reset_ct_addr", ct_addr, 0);
      chk("reset_pt_addr", pt_addr, 0);
      chk("reset_pt_wrdata", pt_wrdata, 0);

      for (int v = 0; v < 3; v++) begin
         load_vec(v);
         run(vecs[v].key, $sformatf("vec%0d", v));
      end

      // en held through reset, then busy-time en pulses
      load_vec(0);
      clear();
      key = vecs[0].key;
      rst = 1'b1;
      en  = 1'b1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (rdy !== 1'b1 || pt_wren !== 1'b0) bad++;
      end
      chk("hs_in_reset", bad, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("hs_start_after_reset", rdy, 0);
      en = 1'b0;
      repeat (3) begin
         repeat (150) @(negedge clk);
         en = 1'b1;
         @(negedge clk);
         en = 1'b0;
         chk("hs_busy_rdy", rdy, 0);
      end
      wait_done("hs", 9);
      check_result("hs");
      repeat (20) @(negedge clk);
      chk("hs_no_rerun_wr", wr_cnt, 10);
      chk("hs_no_rerun_rdy", rdy, 1);

      // reset during key schedule
      load_vec(0);
      clear();
      key = vecs[0].key;
      en  = 1'b1;
      @(negedge clk);
      en  = 1'b0;
      repeat (600) @(negedge clk);
      chk("rst_mid_busy", rdy, 0);
      rst = 1'b1;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (pt_wren !== 1'b0 || rdy !== 1'b1) bad++;
      end
      chk("rst_mid_hold", bad, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_idle", rdy, 1);
      run(vecs[0].key, "after_rst");

      // max length
      ct_mem[0] = 8'd255;
      for (int a = 1; a < 256; a++) ct_mem[a] = 8'($urandom);
      model(24'h1E4600);
      run(24'h1E4600, "maxlen");

      for (int r = 0; r < 3; r++) begin
         logic [23:0] rk;
         rk = 24'($urandom);
         ct_mem[0] = 8'($urandom_range(1, 40));
         for (int a = 1; a < 256; a++) ct_mem[a] = 8'($urandom);
         model(rk);
         run(rk, $sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
